// File: rtl/mem_access_unit_pkg.sv
// Shared types for the load/store unit: funct3 encodings, FSM states and error codes.
// The ld/sd/lwu constants are XLEN-independent; their legality depends on XLEN.
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_SD  = 3'b011;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } lsu_state_t;

    typedef enum logic [1:0] {
        NONE       = 2'b00,
        MISALIGNED = 2'b01,
        TIMEOUT    = 2'b10
    } lsu_err_t;

endpackage

// File: rtl/mem_access_unit_align.sv
// Combinational lane logic: byte enables, store replication, load extraction/extension
// and the misalignment flag (illegal funct3 for this XLEN also raises it).
module lsu_align
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int BW  = XLEN / 8,
    localparam int OW  = $clog2(BW)
) (
    input  logic            i_we,
    input  logic [2:0]      i_funct3,
    input  logic [OW-1:0]   i_offset,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [BW-1:0]   o_byte_enable,
    output logic [XLEN-1:0] o_wdata_rep,
    output logic [XLEN-1:0] o_load_data,
    output logic            o_misaligned
);
    logic [XLEN-1:0] w_lane;

    always_comb begin
        w_lane        = i_rdata >> {i_offset, 3'b000};
        o_byte_enable = '1;
        o_wdata_rep   = i_wdata;
        o_load_data   = '0;
        o_misaligned  = 1'b0;
        if (i_we) begin
            case (i_funct3)
                sb: begin
                    o_byte_enable = BW'(1) << i_offset;
                    o_wdata_rep   = {BW{i_wdata[7:0]}};
                end
                sh: begin
                    o_byte_enable = BW'(3) << i_offset;
                    o_wdata_rep   = {(XLEN/16){i_wdata[15:0]}};
                    o_misaligned  = i_offset[0];
                end
                sw: begin
                    o_byte_enable = BW'(15) << i_offset;
                    o_wdata_rep   = {(XLEN/32){i_wdata[31:0]}};
                    o_misaligned  = |i_offset[1:0];
                end
                F3_SD:   o_misaligned = (XLEN != 64) || (|i_offset);
                default: o_misaligned = 1'b1;
            endcase
        end else begin
            case (i_funct3)
                lb:  o_load_data = XLEN'($signed(w_lane[7:0]));
                lbu: o_load_data = XLEN'(w_lane[7:0]);
                lh: begin
                    o_load_data  = XLEN'($signed(w_lane[15:0]));
                    o_misaligned = i_offset[0];
                end
                lhu: begin
                    o_load_data  = XLEN'(w_lane[15:0]);
                    o_misaligned = i_offset[0];
                end
                lw: begin
                    o_load_data  = XLEN'($signed(w_lane[31:0]));
                    o_misaligned = |i_offset[1:0];
                end
                F3_LWU: begin
                    o_load_data  = XLEN'(w_lane[31:0]);
                    o_misaligned = (XLEN != 64) || (|i_offset[1:0]);
                end
                F3_LD: begin
                    o_load_data  = w_lane;
                    o_misaligned = (XLEN != 64) || (|i_offset);
                end
                default: o_misaligned = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle load/store unit: one request in flight, word-aligned memory access with
// byte enables, extended load data, misalignment and timeout reporting.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic [XLEN-1:0]   mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [XLEN/8-1:0] mem_byte_enable,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_resp,
    output logic [1:0]        dbg_state
);
    localparam int BW = XLEN / 8;
    localparam int OW = $clog2(BW);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    lsu_state_t      r_state, w_next;
    logic            r_we;
    logic [2:0]      r_funct3;
    logic [OW-1:0]   r_offset;
    logic [CW-1:0]   r_cnt;
    logic            r_rsp_valid;
    logic [XLEN-1:0] r_rsp_rdata;
    lsu_err_t        r_rsp_err;
    logic [XLEN-1:0] r_mem_address;
    logic            r_mem_read, r_mem_write;
    logic [BW-1:0]   r_mem_be;
    logic [XLEN-1:0] r_mem_wdata;

    logic            w_accept, w_timeout, w_sel_we, w_misaligned;
    logic [2:0]      w_sel_funct3;
    logic [OW-1:0]   w_sel_offset;
    logic [BW-1:0]   w_be;
    logic [XLEN-1:0] w_wdata_rep, w_load;

    // In IDLE the lane logic sees the incoming request; afterwards the latched one.
    assign w_sel_we     = (r_state == IDLE) ? req_we : r_we;
    assign w_sel_funct3 = (r_state == IDLE) ? req_funct3 : r_funct3;
    assign w_sel_offset = (r_state == IDLE) ? req_addr[OW-1:0] : r_offset;

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_we          (w_sel_we),
        .i_funct3      (w_sel_funct3),
        .i_offset      (w_sel_offset),
        .i_wdata       (req_wdata),
        .i_rdata       (mem_rdata),
        .o_byte_enable (w_be),
        .o_wdata_rep   (w_wdata_rep),
        .o_load_data   (w_load),
        .o_misaligned  (w_misaligned)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_accept  = req_valid && (r_state == IDLE);
        w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TIMEOUT_CYCLES));
        w_next    = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_misaligned ? DONE : ACCESS;
            ACCESS:  if (mem_resp || w_timeout) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we          <= 1'b0;
            r_funct3      <= '0;
            r_offset      <= '0;
            r_cnt         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= NONE;
            r_mem_address <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_be      <= '0;
            r_mem_wdata   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_we          <= req_we;
                    r_funct3      <= req_funct3;
                    r_offset      <= req_addr[OW-1:0];
                    r_cnt         <= '0;
                    r_mem_address <= {req_addr[XLEN-1:OW], {OW{1'b0}}};
                    r_mem_be      <= w_be;
                    r_mem_wdata   <= w_wdata_rep;
                    if (w_misaligned) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= MISALIGNED;
                        r_rsp_rdata <= '0;
                    end else begin
                        r_mem_read  <= !req_we;
                        r_mem_write <= req_we;
                    end
                end
                ACCESS: begin
                    // A response in the final timeout cycle still completes normally.
                    if (mem_resp) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= NONE;
                        r_rsp_rdata <= r_we ? '0 : w_load;
                    end else if (w_timeout) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= TIMEOUT;
                        r_rsp_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE:    r_rsp_valid <= 1'b0;
                default: r_rsp_valid <= 1'b0;
            endcase
        end
    end

    assign req_ready       = (r_state == IDLE);
    assign rsp_valid       = r_rsp_valid;
    assign rsp_rdata       = r_rsp_rdata;
    assign rsp_err         = r_rsp_err;
    assign mem_address     = r_mem_address;
    assign mem_read        = r_mem_read;
    assign mem_write       = r_mem_write;
    assign mem_byte_enable = r_mem_be;
    assign mem_wdata       = r_mem_wdata;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit instance (short timeout) and a 64-bit instance,
// directed scenarios plus randomized transactions against a behavioural model.
`timescale 1ns/1ps
module tb_mem_access_unit;

    localparam int T32 = 4;
    localparam int T64 = 6;

    typedef struct {
        int          rd_cycles;
        int          wr_cycles;
        int          done_cycle;
        int          ready_cycle;
        int          pulses;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [1:0]  err;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_mem_read, a_mem_write, a_mem_resp;
    logic [2:0]  a_req_funct3;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata, a_mem_address, a_mem_wdata, a_mem_rdata;
    logic [1:0]  a_rsp_err, a_dbg;
    logic [3:0]  a_be;

    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_mem_read, b_mem_write, b_mem_resp;
    logic [2:0]  b_req_funct3;
    logic [63:0] b_req_addr, b_req_wdata, b_rsp_rdata, b_mem_address, b_mem_wdata, b_mem_rdata;
    logic [1:0]  b_rsp_err, b_dbg;
    logic [7:0]  b_be;

    mem_access_unit #(.XLEN(32), .TIMEOUT_CYCLES(T32)) dut32 (
        .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .mem_address(a_mem_address), .mem_read(a_mem_read), .mem_write(a_mem_write),
        .mem_byte_enable(a_be), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .mem_resp(a_mem_resp), .dbg_state(a_dbg)
    );

    mem_access_unit #(.XLEN(64), .TIMEOUT_CYCLES(T64)) dut64 (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .mem_address(b_mem_address), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .mem_byte_enable(b_be), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .mem_resp(b_mem_resp), .dbg_state(b_dbg)
    );

    // Access size in bytes; 0 marks a funct3 that is illegal for this XLEN.
    function automatic int acc_size(input logic we, input logic [2:0] f3, input int xlen);
        int sz;
        sz = 0;
        if (we) begin
            case (f3)
                3'd0: sz = 1;
                3'd1: sz = 2;
                3'd2: sz = 4;
                3'd3: sz = (xlen == 64) ? 8 : 0;
                default: sz = 0;
            endcase
        end else begin
            case (f3)
                3'd0, 3'd4: sz = 1;
                3'd1, 3'd5: sz = 2;
                3'd2:       sz = 4;
                3'd6:       sz = (xlen == 64) ? 4 : 0;
                3'd3:       sz = (xlen == 64) ? 8 : 0;
                default:    sz = 0;
            endcase
        end
        return sz;
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input int off, input logic [63:0] rd);
        int sz;
        logic [63:0] v, mask;
        sz   = acc_size(1'b0, f3, 64);
        v    = rd >> (8 * off);
        mask = (sz >= 8) ? {64{1'b1}} : ((64'd1 << (8 * sz)) - 64'd1);
        v    = v & mask;
        if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic obs_t model32(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                     input logic [31:0] wd, input logic [31:0] rd, input int resp);
        obs_t e;
        int sz, off;
        logic [63:0] ld;
        e = '{default: 0};
        sz = acc_size(we, f3, 32);
        off = int'(addr % 4);
        e.pulses = 1;
        e.addr = addr & ~32'h3;
        if (sz == 0 || (off % sz) != 0) begin
            e.done_cycle = 1;
            e.err = 2'b01;
        end else begin
            if (resp >= 1 && resp <= T32 + 1) begin
                e.done_cycle = resp + 1;
                ld = ref_load(f3, off, {32'h0, rd});
                e.rdata = we ? 32'h0 : ld[31:0];
            end else begin
                e.done_cycle = T32 + 2;
                e.err = 2'b10;
            end
            if (we) e.wr_cycles = e.done_cycle - 1;
            else    e.rd_cycles = e.done_cycle - 1;
            e.be = we ? 4'(((1 << sz) - 1) << off) : 4'hF;
            for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
        end
        e.ready_cycle = e.done_cycle + 1;
        return e;
    endfunction

    task automatic run_txn32(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd, input int resp, output obs_t o);
        o = '{default: 0};
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = we; a_req_funct3 = f3; a_req_addr = addr; a_req_wdata = wd;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            a_mem_resp  = (c == resp);
            a_mem_rdata = rd;
            if (a_mem_read)  o.rd_cycles++;
            if (a_mem_write) o.wr_cycles++;
            if (c == 1) begin
                o.addr = a_mem_address; o.be = a_be; o.wdata = a_mem_wdata;
            end
            if (a_rsp_valid) begin
                o.pulses++;
                if (o.done_cycle == 0) begin
                    o.done_cycle = c; o.rdata = a_rsp_rdata; o.err = a_rsp_err;
                end
            end
            if (a_req_ready && o.ready_cycle == 0) o.ready_cycle = c;
        end
        a_mem_resp = 1'b0;
    endtask

    task automatic run_txn64(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] rd,
                             output logic [63:0] got, output logic [1:0] err, output int done,
                             output logic [63:0] maddr, output int rd_cycles);
        got = '0; err = '0; done = 0; maddr = '0; rd_cycles = 0;
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_funct3 = f3; b_req_addr = addr;
        @(posedge clk);
        #1 b_req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            b_mem_resp  = (c == 1);
            b_mem_rdata = rd;
            if (b_mem_read) rd_cycles++;
            if (c == 1) maddr = b_mem_address;
            if (b_rsp_valid && done == 0) begin
                done = c; got = b_rsp_rdata; err = b_rsp_err;
            end
        end
        b_mem_resp = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a_req_valid = 0; a_req_we = 0; a_req_funct3 = 0; a_req_addr = 0; a_req_wdata = 0;
        a_mem_rdata = 0; a_mem_resp = 0;
        b_req_valid = 0; b_req_we = 0; b_req_funct3 = 0; b_req_addr = 0; b_req_wdata = 0;
        b_mem_rdata = 0; b_mem_resp = 0;
        repeat (2) @(negedge clk);
        n_cmp++; if (a_req_ready !== 1'b1) begin n_err++; $display("FAIL reset32 req_ready: got %b exp 1", a_req_ready); end
        n_cmp++; if ({a_rsp_valid, a_rsp_rdata, a_rsp_err, a_mem_address, a_mem_read, a_mem_write, a_be, a_mem_wdata} !== '0)
            begin n_err++; $display("FAIL reset32 outputs: rsp_valid=%b rdata=%h mem_read=%b be=%h exp all 0", a_rsp_valid, a_rsp_rdata, a_mem_read, a_be); end
        n_cmp++; if (b_req_ready !== 1'b1 || {b_rsp_valid, b_rsp_rdata, b_mem_read, b_mem_write, b_be, b_mem_address} !== '0)
            begin n_err++; $display("FAIL reset64 outputs: ready=%b rsp_valid=%b be=%h exp ready=1 rest 0", b_req_ready, b_rsp_valid, b_be); end
        rst = 1'b1;
    endtask

    task automatic test_lb_sign();
        obs_t o;
        run_txn32(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1, o);
        n_cmp++; if (o.addr !== 32'h0000_1000) begin n_err++; $display("FAIL lb mem_address: got %h exp 00001000", o.addr); end
        n_cmp++; if (o.rdata !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb rsp_rdata: got %h exp ffffff80", o.rdata); end
        n_cmp++; if (o.done_cycle != 2) begin n_err++; $display("FAIL lb rsp cycle: got %0d exp 2", o.done_cycle); end
        n_cmp++; if (o.ready_cycle != 3) begin n_err++; $display("FAIL lb ready cycle: got %0d exp 3", o.ready_cycle); end
        n_cmp++; if (o.be !== 4'hF || o.rd_cycles != 1) begin n_err++; $display("FAIL lb strobes: be=%h rd_cycles=%0d exp f/1", o.be, o.rd_cycles); end
    endtask

    task automatic test_sh_delayed();
        obs_t o;
        run_txn32(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h1234_5678, 3, o);
        n_cmp++; if (o.wdata !== 32'hBEEF_BEEF) begin n_err++; $display("FAIL sh mem_wdata: got %h exp beefbeef", o.wdata); end
        n_cmp++; if (o.be !== 4'b1100) begin n_err++; $display("FAIL sh byte_enable: got %b exp 1100", o.be); end
        n_cmp++; if (o.wr_cycles != 3 || o.rd_cycles != 0) begin n_err++; $display("FAIL sh strobe cycles: wr=%0d rd=%0d exp 3/0", o.wr_cycles, o.rd_cycles); end
        n_cmp++; if (o.done_cycle != 4 || o.rdata !== 32'h0 || o.err !== 2'b00)
            begin n_err++; $display("FAIL sh response: cycle=%0d rdata=%h err=%0d exp 4/0/0", o.done_cycle, o.rdata, o.err); end
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_txn32(1'b0, 3'b010, 32'h0000_3002, 32'h0, 32'hFFFF_FFFF, 1, o);
        n_cmp++; if (o.done_cycle != 1 || o.err !== 2'b01) begin n_err++; $display("FAIL lw misaligned: cycle=%0d err=%0d exp 1/1", o.done_cycle, o.err); end
        n_cmp++; if (o.rd_cycles != 0 || o.wr_cycles != 0) begin n_err++; $display("FAIL lw misaligned strobes: rd=%0d wr=%0d exp 0/0", o.rd_cycles, o.wr_cycles); end
        n_cmp++; if (o.ready_cycle != 2 || o.pulses != 1) begin n_err++; $display("FAIL lw misaligned ready/pulses: %0d/%0d exp 2/1", o.ready_cycle, o.pulses); end
        run_txn32(1'b0, 3'b011, 32'h0000_3000, 32'h0, 32'h0, 1, o);
        n_cmp++; if (o.done_cycle != 1 || o.err !== 2'b01 || o.rd_cycles != 0)
            begin n_err++; $display("FAIL ld on xlen32: cycle=%0d err=%0d rd=%0d exp 1/1/0", o.done_cycle, o.err, o.rd_cycles); end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_txn32(1'b0, 3'b101, 32'h0000_4000, 32'h0, 32'hAAAA_5555, 8, o);
        n_cmp++; if (o.rd_cycles != T32 + 1) begin n_err++; $display("FAIL timeout strobe cycles: got %0d exp %0d", o.rd_cycles, T32 + 1); end
        n_cmp++; if (o.done_cycle != T32 + 2 || o.err !== 2'b10 || o.rdata !== 32'h0)
            begin n_err++; $display("FAIL timeout response: cycle=%0d err=%0d rdata=%h exp %0d/2/0", o.done_cycle, o.err, o.rdata, T32 + 2); end
        n_cmp++; if (o.pulses != 1) begin n_err++; $display("FAIL timeout late resp: pulses %0d exp 1", o.pulses); end
        run_txn32(1'b0, 3'b101, 32'h0000_4002, 32'h0, 32'h8001_0000, T32 + 1, o);
        n_cmp++; if (o.done_cycle != T32 + 2 || o.err !== 2'b00 || o.rdata !== 32'h0000_8001)
            begin n_err++; $display("FAIL resp on last cycle: cycle=%0d err=%0d rdata=%h exp %0d/0/00008001", o.done_cycle, o.err, o.rdata, T32 + 2); end
    endtask

    task automatic test_random_ops();
        obs_t o, e;
        logic we;
        logic [2:0] f3;
        logic [31:0] addr, wd, rd, exp_rd;
        int resp;
        logic [2:0] legal_ld [5];
        legal_ld[0] = 3'd0; legal_ld[1] = 3'd1; legal_ld[2] = 3'd2; legal_ld[3] = 3'd4; legal_ld[4] = 3'd5;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we)                   f3 = 3'($urandom_range(0, 2));
            else                           f3 = legal_ld[$urandom_range(0, 4)];
            addr = $urandom;
            if ($urandom_range(0, 2) != 0) addr[0] = 1'b0;
            if ($urandom_range(0, 2) != 0) addr[1] = 1'b0;
            wd = $urandom; rd = $urandom;
            resp = $urandom_range(1, 7);
            e = model32(we, f3, addr, wd, rd, resp);
            exp_q.push_back(e.rdata);
            run_txn32(we, f3, addr, wd, rd, resp, o);
            exp_rd = exp_q.pop_front();
            n_cmp++; if (o.rdata !== exp_rd) begin n_err++; $display("FAIL rand[%0d] rsp_rdata: got %h exp %h", i, o.rdata, exp_rd); end
            n_cmp++; if (o.done_cycle != e.done_cycle || o.err !== e.err)
                begin n_err++; $display("FAIL rand[%0d] response: cycle=%0d err=%0d exp %0d/%0d", i, o.done_cycle, o.err, e.done_cycle, e.err); end
            n_cmp++; if (o.pulses != 1 || o.ready_cycle != e.ready_cycle)
                begin n_err++; $display("FAIL rand[%0d] pulses/ready: %0d/%0d exp 1/%0d", i, o.pulses, o.ready_cycle, e.ready_cycle); end
            n_cmp++; if (o.rd_cycles != e.rd_cycles || o.wr_cycles != e.wr_cycles)
                begin n_err++; $display("FAIL rand[%0d] strobes: rd=%0d wr=%0d exp %0d/%0d", i, o.rd_cycles, o.wr_cycles, e.rd_cycles, e.wr_cycles); end
            if (e.err != 2'b01) begin
                n_cmp++; if (o.addr !== e.addr || o.be !== e.be)
                    begin n_err++; $display("FAIL rand[%0d] addr/be: %h/%h exp %h/%h", i, o.addr, o.be, e.addr, e.be); end
                if (we) begin
                    n_cmp++; if (o.wdata !== e.wdata) begin n_err++; $display("FAIL rand[%0d] mem_wdata: got %h exp %h", i, o.wdata, e.wdata); end
                end
            end
        end
    endtask

    task automatic test_xlen64();
        logic [63:0] got, maddr, addr, rd, exp_v;
        logic [1:0] err;
        logic [2:0] f3;
        int done, rdc, sz, off;
        run_txn64(3'b110, 64'h0000_0000_0000_6004, 64'hDEAD_BEEF_0000_0000, got, err, done, maddr, rdc);
        n_cmp++; if (got !== 64'h0000_0000_DEAD_BEEF) begin n_err++; $display("FAIL lwu64 rsp_rdata: got %h exp 00000000deadbeef", got); end
        n_cmp++; if (maddr !== 64'h6000 || done != 2 || err !== 2'b00)
            begin n_err++; $display("FAIL lwu64 access: addr=%h cycle=%0d err=%0d exp 6000/2/0", maddr, done, err); end
        for (int i = 0; i < 16; i++) begin
            f3 = 3'($urandom_range(0, 7));
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
            if ($urandom_range(0, 1) != 0) addr[2] = 1'b0;
            rd = {$urandom, $urandom};
            sz = acc_size(1'b0, f3, 64);
            off = int'(addr % 8);
            run_txn64(f3, addr, rd, got, err, done, maddr, rdc);
            if (sz == 0 || (off % sz) != 0) begin
                n_cmp++; if (done != 1 || err !== 2'b01 || got !== 64'h0 || rdc != 0)
                    begin n_err++; $display("FAIL rand64[%0d] misaligned: cycle=%0d err=%0d rdata=%h rd=%0d exp 1/1/0/0", i, done, err, got, rdc); end
            end else begin
                exp_v = ref_load(f3, off, rd);
                n_cmp++; if (got !== exp_v || done != 2 || err !== 2'b00)
                    begin n_err++; $display("FAIL rand64[%0d] load f3=%0d: rdata=%h cycle=%0d err=%0d exp %h/2/0", i, f3, got, done, err, exp_v); end
                n_cmp++; if (maddr !== (addr & ~64'h7) || rdc != 1)
                    begin n_err++; $display("FAIL rand64[%0d] mem_address: %h rd=%0d exp %h/1", i, maddr, rdc, addr & ~64'h7); end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        obs_t o;
        int seen;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_funct3 = 3'b010; a_req_addr = 32'h0000_5000;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (a_mem_read !== 1'b1) begin n_err++; $display("FAIL midreset pre mem_read: got %b exp 1", a_mem_read); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (a_mem_read !== 1'b0 || a_req_ready !== 1'b1)
            begin n_err++; $display("FAIL midreset async drop: mem_read=%b ready=%b exp 0/1", a_mem_read, a_req_ready); end
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (a_rsp_valid) seen++;
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (a_rsp_valid) seen++;
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL midreset dropped rsp: %0d pulses exp 0", seen); end
        run_txn32(1'b0, 3'b010, 32'h0000_5004, 32'h0, 32'h1357_9BDF, 2, o);
        n_cmp++; if (o.done_cycle != 3 || o.err !== 2'b00 || o.rdata !== 32'h1357_9BDF)
            begin n_err++; $display("FAIL after reset lw: cycle=%0d err=%0d rdata=%h exp 3/0/13579bdf", o.done_cycle, o.err, o.rdata); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lb_sign();
        test_sh_delayed();
        test_misaligned();
        test_timeout();
        test_random_ops();
        test_xlen64();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
